// File: rtl/bus_arbiter.sv
// Round-robin owner/sequencer for the shared serial bus: grant, decode slave id, connect, release.
// Optional CONNECT watchdog under ARB_TIMEOUT_EN (timeout_err tied low when undefined).
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int SEL_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_address,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_SLAVES-1:0]  slave_sel,
  input  logic [NUM_SLAVES-1:0]  slave_rx_done,
  input  logic [NUM_SLAVES-1:0]  slave_tx_done,
  output logic                   bus_busy,
  output logic                   decode_err,
  output logic                   timeout_err
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(SEL_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CONNECT, S_RELEASE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [MW-1:0]          r_gidx, w_gidx_nxt, r_ptr, w_ptr_nxt, w_pick;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [NUM_SLAVES-1:0]  r_sel, w_sel_nxt, w_sel_oh;
  logic [SEL_BITS-1:0]    r_id, w_id_nxt, w_id_full;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   r_dec_err, w_dec_err_nxt, r_tmo_err, w_tmo_err_nxt;
  logic                   w_found, w_done, w_req_g, w_vld_g, w_addr_g, w_tmo_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Held at zero outside CONNECT, so every CONNECT entry starts from a cleared count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_tmo_cnt <= '0;
    else if (r_state != S_CONNECT) r_tmo_cnt <= '0;
    else                         r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end
  assign w_tmo_hit = (r_state == S_CONNECT) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  assign w_req_g  = m_req[r_gidx];
  assign w_vld_g  = m_valid[r_gidx];
  assign w_addr_g = m_address[r_gidx];
  assign w_done   = |((slave_rx_done | slave_tx_done) & r_sel);

  always_comb begin
    int k;
    k       = 0;
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      k = int'(r_ptr) + i;
      if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
      if (!w_found && m_req[MW'(k)]) begin
        w_found = 1'b1;
        w_pick  = MW'(k);
      end
    end
  end

  always_comb begin
    w_id_full        = r_id;
    w_id_full[r_cnt] = w_addr_g;
    for (int s = 0; s < NUM_SLAVES; s++) w_sel_oh[s] = (int'(w_id_full) == s);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gidx_nxt    = r_gidx;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_id_nxt      = r_id;
    w_cnt_nxt     = r_cnt;
    w_dec_err_nxt = 1'b0;
    w_tmo_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: if (w_found) begin
        w_grant_nxt = NUM_MASTERS'(1) << w_pick;
        w_gidx_nxt  = w_pick;
        w_id_nxt    = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (!w_req_g) begin
          w_grant_nxt = '0;
          w_state_nxt = S_RELEASE;
        end else if (w_vld_g) begin
          w_id_nxt  = w_id_full;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(SEL_BITS - 1)) begin
            if (int'(w_id_full) < NUM_SLAVES) begin
              w_sel_nxt   = w_sel_oh;
              w_state_nxt = S_CONNECT;
            end else begin
              w_dec_err_nxt = 1'b1;
              w_grant_nxt   = '0;
              w_state_nxt   = S_RELEASE;
            end
          end
        end
      end
      S_CONNECT: if (w_done || !w_req_g || w_tmo_hit) begin
        // A done on the same cycle as a drop or the terminal count is a normal completion.
        w_tmo_err_nxt = w_tmo_hit && !w_done && w_req_g;
        w_grant_nxt   = '0;
        w_sel_nxt     = '0;
        w_state_nxt   = S_RELEASE;
      end
      default: begin
        w_ptr_nxt   = (r_gidx == MW'(NUM_MASTERS - 1)) ? '0 : r_gidx + MW'(1);
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_gidx    <= '0;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_sel     <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      r_dec_err <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gidx    <= w_gidx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_id      <= w_id_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dec_err <= w_dec_err_nxt;
      r_tmo_err <= w_tmo_err_nxt;
    end
  end

  assign m_grant     = r_grant;
  assign slave_sel   = r_sel;
  assign bus_busy    = (r_state != S_IDLE);
  assign decode_err  = r_dec_err;
  assign timeout_err = r_tmo_err;

endmodule
